// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-box depth and the init-loop state encoding.
package rc4_pkg;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/task1_s_init.sv
// RC4 KSA init loop: on start, writes S[i] = i for every entry, then pulses fin_strobe.
module task1_s_init
  import rc4_pkg::*;
#(
  parameter int MEM_DEPTH = rc4_pkg::MEM_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       wr_en,
  output logic       task_on,
  output logic       fin_strobe
);

  localparam logic [7:0] LAST = 8'(MEM_DEPTH - 1);

  state_t     state, state_nxt;
  logic [7:0] i, i_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      i     <= '0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
    end
  end

  // Outputs are a pure decode of the state register and counter, so they
  // follow reset immediately and wr_en only rises in WRITE.
  always_comb begin
    state_nxt  = state;
    i_nxt      = i;
    address    = '0;
    data       = '0;
    wr_en      = 1'b0;
    task_on    = 1'b0;
    fin_strobe = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          i_nxt     = '0;
        end
      end
      WRITE: begin
        address = i;
        data    = i;
        wr_en   = 1'b1;
        task_on = 1'b1;
        if (i == LAST) begin
          state_nxt = DONE;
          i_nxt     = '0;
        end else begin
          i_nxt = i + 8'd1;
        end
      end
      DONE: begin
        task_on    = 1'b1;
        fin_strobe = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_task1_s_init.sv
// Randomized scoreboard bench for task1_s_init: a timeline model queues expected writes/strobes.
module tb_task1_s_init;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] address, data;
  logic       wr_en, task_on, fin_strobe;

  int tests = 0;
  int fails = 0;

  task1_s_init #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start),
    .address(address), .data(data), .wr_en(wr_en),
    .task_on(task_on), .fin_strobe(fin_strobe)
  );

  always #5 clk = ~clk;

  // Consumer-side S memory.
  logic [7:0] s_mem [256];
  always @(posedge clk) if (wr_en) s_mem[address] <= data;

  // Reference timeline: a run accepted at edge k writes 0..255 on edges
  // k+1..k+256, strobes after edge k+256 and is idle again at edge k+257.
  int  cyc = 0;
  bit  m_busy = 1'b0;
  int  m_end = 0;
  int  wq[$];
  int  fq[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      wq.delete();
      fq.delete();
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_end) m_busy = 1'b0;
    end else if (start) begin
      m_busy = 1'b1;
      m_end  = cyc + 257;
      for (int j = 0; j < 256; j++) wq.push_back(j);
      fq.push_back(cyc + 256);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes or strobes.
  int wcount = 0;
  always @(negedge clk) begin
    int e;
    if (!rst) wcount = 0;
    if (wr_en) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: addr=%0d data=%0d, required no write", address, data);
      end else begin
        e = wq.pop_front();
        if (address != 8'(e) || data != 8'(e) || !task_on || fin_strobe) begin
          fails++;
          $display("FAIL write_seq: addr=%0d data=%0d task_on=%0b fin=%0b, required addr=data=%0d task_on=1 fin=0",
                   address, data, task_on, fin_strobe, e);
        end
      end
      wcount++;
    end else if (fin_strobe) begin
      tests++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL fin_unexpected: fin_strobe at cycle %0d, required none", cyc);
      end else begin
        e = fq.pop_front();
        if (cyc != e || wcount != 256 || !task_on || wq.size() != 0) begin
          fails++;
          $display("FAIL fin_timing: cycle=%0d writes=%0d task_on=%0b pending=%0d, required cycle=%0d writes=256 task_on=1 pending=0",
                   cyc, wcount, task_on, wq.size(), e);
        end
      end
      wcount = 0;
    end else begin
      tests++;
      if (task_on || address != 8'd0 || data != 8'd0) begin
        fails++;
        $display("FAIL idle_outputs: task_on=%0b addr=%0d data=%0d, required 0/0/0", task_on, address, data);
      end
    end
  end

  task automatic check_idle_now(input string name);
    tests++;
    if (address != 8'd0 || data != 8'd0 || wr_en || task_on || fin_strobe) begin
      fails++;
      $display("FAIL %s: addr=%0d data=%0d wr_en=%0b task_on=%0b fin=%0b, required all 0",
               name, address, data, wr_en, task_on, fin_strobe);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (fin_strobe) break;
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL fin_timeout: no fin_strobe within %0d cycles, required one", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (wq.size() != 0 || fq.size() != 0) begin
      fails++;
      $display("FAIL %s: pending writes=%0d strobes=%0d, required 0/0", name, wq.size(), fq.size());
    end
  endtask

  // One run with start wiggled while busy (or poked once at i=100).
  task automatic run_random(input bit poke100);
    int gap = $urandom_range(0, 5);
    repeat (gap) @(posedge clk);
    pulse_start();
    for (int c = 1; c <= 250; c++) begin
      @(posedge clk); #1;
      start = poke100 ? (c == 100) : 1'($urandom % 2);
    end
    start = 1'b0;
    wait_fin(20);
    check_drained("run_drained");
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    #1 check_idle_now("reset_outputs");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_now("no_auto_run");

    // First run, then read S back.
    pulse_start();
    wait_fin(300);
    for (int j = 0; j < 256; j++) begin
      tests++;
      if (s_mem[j] != 8'(j)) begin
        fails++;
        $display("FAIL readback[%0d]: got %0d, required %0d", j, s_mem[j], j);
      end
    end

    run_random(1'b1);
    for (int r = 0; r < 3; r++) run_random(1'b0);

    // Abort at i=50: outputs drop immediately, no strobe follows.
    pulse_start();
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_idle_now("reset_mid_write");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_drained("abort_drained");
    run_random(1'b0);

    // start held high: back-to-back runs.
    @(posedge clk); #1 start = 1'b1;
    repeat (600) @(posedge clk);
    #1 start = 1'b0;
    begin
      int n = 0;
      while (m_busy && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 1000) begin
        tests++;
        fails++;
        $display("FAIL held_timeout: model still busy after %0d cycles", n);
      end
    end
    repeat (2) @(posedge clk);
    #1 check_drained("held_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
